// File: rtl/imp_sqr_iter.sv
// imp_sqr_iter: iterative squarer built from nibble-pair partial products.
// The operand magnitude is split into K = DATA_W/4 nibbles. One nibble pair
// (i,j), i<=j, is folded into a 2*DATA_W accumulator per clock. Squares come
// from a 4-bit square table. Cross products use quarter-squares over a 5-bit
// square table, so the block contains no multiplier.
module imp_sqr_iter #(
  parameter int DATA_W    = 16,
  parameter int SIGNED_IN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_data,
  output logic                  busy
);

  localparam int K  = DATA_W / 4;
  localparam int AW = 2 * DATA_W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mag;
  logic [AW-1:0]     acc;
  logic [IW-1:0]     i_idx;
  logic [IW-1:0]     j_idx;

  logic [3:0]        ni;
  logic [3:0]        nj;
  logic [4:0]        nsum;
  logic [4:0]        ndif;
  logic [9:0]        qdiff;
  logic [8:0]        cross2;
  logic [IW:0]       ij_sum;
  logic [AW-1:0]     term;
  logic [AW-1:0]     acc_nxt;

  // 16-entry table of 4-bit squares, used on the diagonal pairs
  function automatic logic [7:0] sq4(input logic [3:0] n);
    case (n)
      4'd0:  sq4 = 8'd0;
      4'd1:  sq4 = 8'd1;
      4'd2:  sq4 = 8'd4;
      4'd3:  sq4 = 8'd9;
      4'd4:  sq4 = 8'd16;
      4'd5:  sq4 = 8'd25;
      4'd6:  sq4 = 8'd36;
      4'd7:  sq4 = 8'd49;
      4'd8:  sq4 = 8'd64;
      4'd9:  sq4 = 8'd81;
      4'd10: sq4 = 8'd100;
      4'd11: sq4 = 8'd121;
      4'd12: sq4 = 8'd144;
      4'd13: sq4 = 8'd169;
      4'd14: sq4 = 8'd196;
      4'd15: sq4 = 8'd225;
    endcase
  endfunction

  // 32-entry table of 5-bit squares, feeding the quarter-square products
  function automatic logic [9:0] sq5(input logic [4:0] n);
    case (n)
      5'd0:  sq5 = 10'd0;
      5'd1:  sq5 = 10'd1;
      5'd2:  sq5 = 10'd4;
      5'd3:  sq5 = 10'd9;
      5'd4:  sq5 = 10'd16;
      5'd5:  sq5 = 10'd25;
      5'd6:  sq5 = 10'd36;
      5'd7:  sq5 = 10'd49;
      5'd8:  sq5 = 10'd64;
      5'd9:  sq5 = 10'd81;
      5'd10: sq5 = 10'd100;
      5'd11: sq5 = 10'd121;
      5'd12: sq5 = 10'd144;
      5'd13: sq5 = 10'd169;
      5'd14: sq5 = 10'd196;
      5'd15: sq5 = 10'd225;
      5'd16: sq5 = 10'd256;
      5'd17: sq5 = 10'd289;
      5'd18: sq5 = 10'd324;
      5'd19: sq5 = 10'd361;
      5'd20: sq5 = 10'd400;
      5'd21: sq5 = 10'd441;
      5'd22: sq5 = 10'd484;
      5'd23: sq5 = 10'd529;
      5'd24: sq5 = 10'd576;
      5'd25: sq5 = 10'd625;
      5'd26: sq5 = 10'd676;
      5'd27: sq5 = 10'd729;
      5'd28: sq5 = 10'd784;
      5'd29: sq5 = 10'd841;
      5'd30: sq5 = 10'd900;
      5'd31: sq5 = 10'd961;
    endcase
  endfunction

  // Unsigned magnitude of the operand; the most-negative code maps onto
  // 2^(DATA_W-1), which is still representable as DATA_W unsigned bits.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] xs;
    xs = $signed(x);
    if (SIGNED_IN != 0 && xs < 0)
      magnitude = $unsigned(-xs);
    else
      magnitude = x;
  endfunction

  // Partial product of the current nibble pair, aligned to its weight
  always_comb begin
    ni      = 4'(mag >> {i_idx, 2'b00});
    nj      = 4'(mag >> {j_idx, 2'b00});
    nsum    = {1'b0, ni} + {1'b0, nj};
    ndif    = (ni >= nj) ? {1'b0, ni - nj} : {1'b0, nj - ni};
    // (a+b)^2 - (a-b)^2 = 4ab; halving it yields the doubled cross term
    qdiff   = sq5(nsum) - sq5(ndif);
    cross2  = 9'(qdiff >> 1);
    ij_sum  = {1'b0, i_idx} + {1'b0, j_idx};
    term    = '0;
    if (i_idx == j_idx)
      term = AW'(sq4(ni)) << {i_idx, 3'b000};
    else
      term = AW'(cross2) << {ij_sum, 2'b00};
    acc_nxt = acc + term;
  end

  // Control FSM with registered handshake outputs and the accumulator datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      mag       <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
    end else if (clear) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag      <= magnitude(in_data);
            acc      <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (i_idx == LAST && j_idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= acc_nxt;
          end else if (j_idx == LAST) begin
            i_idx <= i_idx + 1'b1;
            j_idx <= i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imp_sqr_iter.sv
// Bench for imp_sqr_iter: six instances (16/8/4-bit, unsigned and signed)
// driven from a table of known squares, randomized operands and sweeps.
module tb_imp_sqr_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [5:0]  iv;
  logic [5:0]  ordy;
  wire  [5:0]  ir;
  wire  [5:0]  ov;
  wire  [5:0]  bz;
  logic [15:0] d0, d1;
  logic [7:0]  d2, d3;
  logic [3:0]  d4, d5;
  wire  [31:0] o0, o1;
  wire  [15:0] o2, o3;
  wire  [7:0]  o4, o5;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int p_of[6] = '{10, 10, 3, 3, 1, 1};
  int w_of[6] = '{16, 16, 8, 8, 4, 4};
  bit s_of[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    int          k;
    logic [15:0] x;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  imp_sqr_iter #(.DATA_W(16), .SIGNED_IN(0)) u0 (.clk(clk), .rst_n(rst_n), .clear(clr),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(o0), .busy(bz[0]));
  imp_sqr_iter #(.DATA_W(16), .SIGNED_IN(1)) u1 (.clk(clk), .rst_n(rst_n), .clear(clr),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(o1), .busy(bz[1]));
  imp_sqr_iter #(.DATA_W(8), .SIGNED_IN(0)) u2 (.clk(clk), .rst_n(rst_n), .clear(clr),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d2), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(o2), .busy(bz[2]));
  imp_sqr_iter #(.DATA_W(8), .SIGNED_IN(1)) u3 (.clk(clk), .rst_n(rst_n), .clear(clr),
    .in_valid(iv[3]), .in_ready(ir[3]), .in_data(d3), .out_valid(ov[3]),
    .out_ready(ordy[3]), .out_data(o3), .busy(bz[3]));
  imp_sqr_iter #(.DATA_W(4), .SIGNED_IN(0)) u4 (.clk(clk), .rst_n(rst_n), .clear(clr),
    .in_valid(iv[4]), .in_ready(ir[4]), .in_data(d4), .out_valid(ov[4]),
    .out_ready(ordy[4]), .out_data(o4), .busy(bz[4]));
  imp_sqr_iter #(.DATA_W(4), .SIGNED_IN(1)) u5 (.clk(clk), .rst_n(rst_n), .clear(clr),
    .in_valid(iv[5]), .in_ready(ir[5]), .in_data(d5), .out_valid(ov[5]),
    .out_ready(ordy[5]), .out_data(o5), .busy(bz[5]));

  // Reference: square of the operand's value read as W-bit unsigned or signed
  function automatic logic [31:0] ref_sq(input int k, input logic [15:0] x);
    longint m, v;
    m = longint'(1) << w_of[k];
    v = longint'(x) % m;
    if (s_of[k] && v >= m / 2) v = m - v;
    return 32'(v * v);
  endfunction

  function automatic logic [31:0] get_od(input int k);
    case (k)
      0:       return o0;
      1:       return o1;
      2:       return {16'h0, o2};
      3:       return {16'h0, o3};
      4:       return {24'h0, o4};
      default: return {24'h0, o5};
    endcase
  endfunction

  task automatic set_din(input int k, input logic [15:0] x);
    case (k)
      0:       d0 = x;
      1:       d1 = x;
      2:       d2 = x[7:0];
      3:       d3 = x[7:0];
      4:       d4 = x[3:0];
      default: d5 = x[3:0];
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // One full transaction on instance k; stall<0 picks a random DONE stall
  task automatic do_op(input int k, input logic [15:0] x, input int stall,
                       input bit junk, output logic [31:0] res);
    int n;
    int s;
    logic [31:0] first;
    n = 0;
    while (!ir[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", 64'(ir[k]), 64'd1);
    set_din(k, x);
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    chk("calc_busy", 64'(bz[k]), 64'd1);
    chk("calc_nready", 64'(ir[k]), 64'd0);
    n = 0;
    while (!ov[k] && n < 200) begin
      if (junk) begin
        iv[k]   = 1'($urandom);
        ordy[k] = 1'($urandom);
        set_din(k, 16'($urandom));
      end
      @(posedge clk); #1; n++;
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b0;
    chk("latency", 64'(n), 64'(p_of[k]));
    first = get_od(k);
    s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    for (int c = 0; c < s; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(ov[k]), 64'd1);
      chk("hold_data", 64'(get_od(k)), 64'(first));
      chk("hold_nready", 64'(ir[k]), 64'd0);
    end
    res = first;
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk("post_valid", 64'(ov[k]), 64'd0);
    chk("post_data", 64'(get_od(k)), 64'd0);
    chk("post_ready", 64'(ir[k]), 64'd1);
    chk("post_busy", 64'(bz[k]), 64'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [15:0] x;
    bit          seen;
    int          n;

    vecs[0]  = '{0, 16'h1234, 32'h014B5A90};
    vecs[1]  = '{0, 16'hFFFF, 32'hFFFE0001};
    vecs[2]  = '{1, 16'hFFFF, 32'h00000001};
    vecs[3]  = '{1, 16'h8000, 32'h40000000};
    vecs[4]  = '{0, 16'h8000, 32'h40000000};
    vecs[5]  = '{1, 16'h7FFF, 32'h3FFF0001};
    vecs[6]  = '{0, 16'h0000, 32'h00000000};
    vecs[7]  = '{1, 16'h0003, 32'h00000009};
    vecs[8]  = '{2, 16'h00FF, 32'h0000FE01};
    vecs[9]  = '{3, 16'h0080, 32'h00004000};
    vecs[10] = '{4, 16'h000F, 32'h000000E1};
    vecs[11] = '{5, 16'h0008, 32'h00000040};
    vecs[12] = '{5, 16'h000F, 32'h00000001};

    rst_n = 1'b0; clr = 1'b0; iv = '0; ordy = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0; d5 = '0;
    #12;
    chk("rst_in_ready", 64'(ir), 64'h3F);
    chk("rst_out_valid", 64'(ov), 64'h0);
    chk("rst_busy", 64'(bz), 64'h0);
    chk("rst_out_data", 64'(o0), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Known squares, including the boundary codes
    for (int v = 0; v < 13; v++) begin
      do_op(vecs[v].k, vecs[v].x, 0, 1'b0, res);
      chk("vector", 64'(res), 64'(vecs[v].exp));
    end

    // Back-pressure: result held five cycles while out_ready is low
    do_op(0, 16'h1234, 5, 1'b0, res);
    chk("stall5_result", 64'(res), 64'h014B5A90);
    // Junk on in_valid/in_data/out_ready while busy
    do_op(0, 16'h1234, 2, 1'b1, res);
    chk("junk_result", 64'(res), 64'h014B5A90);

    // Clear on the fourth CALC cycle
    set_din(0, 16'h1234);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_in_ready", 64'(ir[0]), 64'd1);
    chk("clr_out_valid", 64'(ov[0]), 64'd0);
    chk("clr_out_data", 64'(o0), 64'd0);
    chk("clr_busy", 64'(bz[0]), 64'd0);
    // A handshake coincident with clear is dropped
    clr = 1'b1; iv[0] = 1'b1; set_din(0, 16'h0055);
    @(posedge clk); #1;
    clr = 1'b0; iv[0] = 1'b0;
    chk("clr_drop_ready", 64'(ir[0]), 64'd1);
    chk("clr_drop_busy", 64'(bz[0]), 64'd0);
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; seen |= ov[0]; end
    chk("clr_no_valid", 64'(seen), 64'd0);
    do_op(0, 16'h0003, 0, 1'b0, res);
    chk("clr_next_op", 64'(res), 64'h9);

    // Asynchronous reset while holding a result in DONE
    set_din(0, 16'h1234);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 200) begin @(posedge clk); #1; n++; end
    chk("rstd_reached_done", 64'(ov[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstd_out_valid", 64'(ov[0]), 64'd0);
    chk("rstd_out_data", 64'(o0), 64'd0);
    chk("rstd_in_ready", 64'(ir[0]), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstd_ready_after", 64'(ir[0]), 64'd1);
    chk("rstd_busy_after", 64'(bz[0]), 64'd0);
    do_op(0, 16'h0003, 0, 1'b0, res);
    chk("rstd_next_op", 64'(res), 64'h9);

    // Randomized 16-bit operands against the reference model
    for (int t = 0; t < 40; t++) begin
      x = 16'($urandom);
      do_op(t % 2, x, -1, 1'b1, res);
      chk("rand16", 64'(res), 64'(ref_sq(t % 2, x)));
    end

    // Exhaustive sweeps of the 8-bit and 4-bit variants
    for (int k = 2; k < 6; k++) begin
      for (int v = 0; v < (1 << w_of[k]); v++) begin
        x = 16'(v);
        do_op(k, x, -1, (v % 3) == 0, res);
        chk("sweep", 64'(res), 64'(ref_sq(k, x)));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imp_sqr_iter.md
IMP_SQR_ITER -- requirements
Module: imp_sqr_iter

Interface
REQ-001 Parameter DATA_W, default 16, input width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter SIGNED_IN, default 1; 1 = in_data is two's complement, 0 = unsigned.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous abort; returns block to IDLE.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 in_data  input  DATA_W  operand x.
REQ-009 out_valid  output  1  out_data holds x*x.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  2*DATA_W  unsigned square of x.
REQ-012 busy  output  1  high in CALC or DONE.

Function
REQ-013 K = DATA_W/4 nibbles; P = K*(K+1)/2 nibble pairs (i,j) with 0<=i<=j<K; P=10 at default.
REQ-014 States SHALL be IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid && in_ready, latch magnitude |x| (SIGNED_IN=1) or x (SIGNED_IN=0) as DATA_W unsigned bits, clear accumulator and pair index, go to CALC.
REQ-016 Magnitude of most-negative input (-2^(DATA_W-1)) SHALL be 2^(DATA_W-1), with no overflow.
REQ-017 CALC: exactly one pair per clock in order (0,0),(0,1)..(0,K-1),(1,1)..(K-1,K-1); the accumulator adds n_i^2<<8i when i==j, else (2*n_i*n_j)<<4(i+j).
REQ-018 Nibble squares SHALL come from an internal 16-entry 4-bit square table; cross products SHALL use quarter-squares n_i*n_j = (S5(n_i+n_j) - S5(|n_i-n_j|))/4 with a 32-entry 5-bit square table; no generic multiplier is permitted.
REQ-019 The accumulator SHALL be 2*DATA_W bits wide; the final value SHALL never overflow it.
REQ-020 After the P-th CALC edge go to DONE; out_valid rises exactly P cycles after the accepting edge.
REQ-021 DONE: hold out_data and out_valid stable until out_valid && out_ready, then go to IDLE; in_ready rises the following cycle, so operations never overlap.
REQ-022 in_data and in_valid changes during CALC/DONE SHALL be ignored; the latched operand governs the result.
REQ-023 clear SHALL override all other inputs in any state: next state IDLE, out_valid=0, out_data=0, accumulator=0; a handshake coincident with clear SHALL be dropped.
REQ-024 out_ready while not in DONE SHALL have no effect.
REQ-025 out_data SHALL equal the accumulator only in DONE and SHALL be 0 in IDLE/CALC.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, and clear the accumulator, pair index and latched operand.
REQ-027 Reset asserted mid-CALC or in DONE SHALL discard the operation; the first accept after release SHALL behave as from power-up.

Verification
REQ-028 DATA_W=16, SIGNED_IN=0, in_data=0x1234 -> out_valid 10 cycles after accept, out_data=0x014B5A90.
REQ-029 SIGNED_IN=0, 0xFFFF -> 0xFFFE0001; SIGNED_IN=1, 0xFFFF (-1) -> 0x00000001; SIGNED_IN=1, 0x8000 -> 0x40000000.
REQ-030 out_ready held low 5 cycles in DONE -> out_data stable, in_ready=0; in_valid toggled with junk data during CALC -> result unchanged.
REQ-031 clear pulsed on the 4th CALC cycle -> IDLE next cycle, out_valid never asserts, next operand 0x0003 -> 0x00000009.
REQ-032 rst_n pulsed low in DONE -> out_valid and out_data drop to 0 asynchronously, in_ready=1 after release.
REQ-033 Exhaustive sweep of DATA_W=8 (both SIGNED_IN values, all 256 inputs, random out_ready stalls) and DATA_W=4 (P=1) -> every out_data matches a reference square model.
